// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request sequencer: opcodes, FSM encoding, default widths.
package alu_pkg;

    localparam int unsigned W_DEF   = 8;
    localparam int unsigned OPW_DEF = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_request_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first set request scanning from ptr upward, wrapping mod NREQ.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] win,
    output logic [IDXW-1:0] win_idx
);

    // Scan offsets from farthest to nearest so the nearest set request wins last.
    always_comb begin
        int unsigned j;
        j       = 0;
        win_idx = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            j = (32'(ptr) + 32'(i)) % NREQ;
            if (req[j]) begin
                win_idx = IDXW'(j);
            end
        end
        win = (|req) ? (NREQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/alu_request_sequencer.sv
// Round-robin sharing of one fixed-latency ALU among NREQ requesters.
module alu_request_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = W_DEF,
    parameter int unsigned OPW     = OPW_DEF,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*OPW-1:0] op_in,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      result,
    output logic              zero,
    output logic              carry,
    output logic [OPW-1:0]    alu_op,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic              alu_start,
    input  logic [W-1:0]      alu_y,
    input  logic              alu_c
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] cur;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] win;
    logic [IDXW-1:0] win_idx;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx)
    );

    // Sequencer FSM: grant/latch, launch, wait latency, capture, acknowledge.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= S_IDLE;
            gnt       <= '0;
            done      <= '0;
            alu_start <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            carry     <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            ptr       <= '0;
            cur       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= '0;
                    gnt  <= '0;
                    if (|req) begin
                        gnt    <= win;
                        cur    <= win_idx;
                        alu_op <= op_in[win_idx*OPW +: OPW];
                        alu_a  <= a_in[win_idx*W +: W];
                        alu_b  <= b_in[win_idx*W +: W];
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    alu_start <= 1'b1;
                    cnt       <= CW'(ALU_LAT - 1);
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    alu_start <= 1'b0;
                    if (cnt == '0) begin
                        result <= alu_y;
                        carry  <= alu_c;
                        zero   <= (alu_y == '0);
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    // gnt is left untouched so done and gnt overlap for the pulse cycle.
                    done  <= gnt;
                    ptr   <= (cur == IDXW'(NREQ - 1)) ? '0 : cur + IDXW'(1);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_request_sequencer.sv
// Directed bench: 4-requester sequencer with a latency-2 ALU model, plus a 3-requester latency-1 instance.
module tb_alu_request_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 4-requester instance
    logic        rst4;
    logic [3:0]  req;
    logic [15:0] op_in;
    logic [31:0] a_in, b_in;
    logic [3:0]  gnt, done;
    logic [7:0]  result, alu_a, alu_b, alu_y;
    logic        zero, carry, alu_start, alu_c;
    logic [3:0]  alu_op;

    // 3-requester instance
    logic        rst3;
    logic [2:0]  req3;
    logic [11:0] op3;
    logic [23:0] a3, b3;
    logic [2:0]  gnt3, done3;
    logic [7:0]  result3, alu_a3, alu_b3, alu_y3;
    logic        zero3, carry3, alu_start3, alu_c3;
    logic [3:0]  alu_op3;

    alu_request_sequencer #(.NREQ(4), .W(8), .OPW(4), .ALU_LAT(2)) dut4 (
        .Clk(clk), .Reset(rst4), .req(req), .op_in(op_in), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .done(done), .result(result), .zero(zero), .carry(carry),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
        .alu_y(alu_y), .alu_c(alu_c)
    );

    alu_request_sequencer #(.NREQ(3), .W(8), .OPW(4), .ALU_LAT(1)) dut3 (
        .Clk(clk), .Reset(rst3), .req(req3), .op_in(op3), .a_in(a3), .b_in(b3),
        .gnt(gnt3), .done(done3), .result(result3), .zero(zero3), .carry(carry3),
        .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_start(alu_start3),
        .alu_y(alu_y3), .alu_c(alu_c3)
    );

    // Reference ALU function: {carry/borrow, result}
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  alu_f = {1'b0, a} + {1'b0, b};
            OP_SUB:  alu_f = {1'b0, a} - {1'b0, b};
            OP_AND:  alu_f = {1'b0, a & b};
            OP_OR:   alu_f = {1'b0, a | b};
            OP_XOR:  alu_f = {1'b0, a ^ b};
            default: alu_f = 9'h000;
        endcase
    endfunction

    // Latency-2 ALU model: output valid only in the cycle sampled two edges after alu_start rises.
    logic [3:0] age = 4'd15;
    always @(posedge clk) begin
        if (alu_start)        age <= 4'd1;
        else if (age != 4'd15) age <= age + 4'd1;
    end
    always_comb begin
        if (age == 4'd1) {alu_c, alu_y} = alu_f(alu_op, alu_a, alu_b);
        else             {alu_c, alu_y} = {1'b1, 8'h5A};
    end

    // Latency-1 instance sees a combinational ALU.
    assign {alu_c3, alu_y3} = alu_f(alu_op3, alu_a3, alu_b3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set4(input int k, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        op_in[k*4 +: 4] = op;
        a_in[k*8 +: 8]  = a;
        b_in[k*8 +: 8]  = b;
    endtask

    // Structural invariants on both instances, sampled on the falling edge.
    always @(negedge clk) begin
        chk("onehot_gnt4", 32'($onehot0(gnt)), 32'd1);
        chk("done_in_gnt4", 32'(done & ~gnt), 32'd0);
        chk("onehot_done3", 32'($onehot0(done3)), 32'd1);
        chk("done_in_gnt3", 32'(done3 & ~gnt3), 32'd0);
    end

    initial begin
        logic [8:0] e;
        int         k;
        logic [2:0] pat [9];
        int         eg  [9];

        rst4 = 1'b0; rst3 = 1'b0;
        req = 4'b1111; op_in = '0; a_in = '0; b_in = '0;
        req3 = '0; op3 = '0; a3 = '0; b3 = '0;

        // 1: reset with all requests high
        repeat (2) step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_start", 32'(alu_start), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);

        // 2: single request from index 2, ADD 0F+01
        set4(2, OP_ADD, 8'h0F, 8'h01);
        req = 4'b0100; rst4 = 1'b1;
        step();
        chk("t2_gnt", 32'(gnt), 32'h4);
        chk("t2_start0", 32'(alu_start), 32'd0);
        step();
        chk("t2_start1", 32'(alu_start), 32'd1);
        chk("t2_alu_a", 32'(alu_a), 32'h0F);
        chk("t2_alu_b", 32'(alu_b), 32'h01);
        chk("t2_alu_op", 32'(alu_op), 32'(OP_ADD));
        step();
        chk("t2_start2", 32'(alu_start), 32'd0);
        chk("t2_done_e2", 32'(done), 32'd0);
        step();
        chk("t2_done_e3", 32'(done), 32'd0);
        step();
        chk("t2_done", 32'(done), 32'h4);
        chk("t2_gnt_hold", 32'(gnt), 32'h4);
        chk("t2_result", 32'(result), 32'h10);
        chk("t2_zero", 32'(zero), 32'd0);
        chk("t2_carry", 32'(carry), 32'd0);
        req = 4'b0000;
        step();
        chk("t2_gnt_clr", 32'(gnt), 32'd0);
        chk("t2_done_clr", 32'(done), 32'd0);

        // 3: all requests held for 8 ops, rotation from ptr 0 with period 5
        rst4 = 1'b0;
        step();
        set4(0, OP_ADD, 8'h01, 8'h01);
        set4(1, OP_SUB, 8'h11, 8'h02);
        set4(2, OP_AND, 8'h21, 8'h03);
        set4(3, OP_XOR, 8'h31, 8'h04);
        req = 4'b1111; rst4 = 1'b1;
        for (int n = 0; n < 8; n++) begin
            k = n % 4;
            step();
            chk($sformatf("t3_gnt_%0d", n), 32'(gnt), 32'(4'b0001 << k));
            chk($sformatf("t3_alu_a_%0d", n), 32'(alu_a), 32'(8'h10 * k + 1));
            repeat (3) step();
            chk($sformatf("t3_nodone_%0d", n), 32'(done), 32'd0);
            step();
            e = alu_f(op_in[k*4 +: 4], a_in[k*8 +: 8], b_in[k*8 +: 8]);
            chk($sformatf("t3_done_%0d", n), 32'(done), 32'(4'b0001 << k));
            chk($sformatf("t3_result_%0d", n), 32'(result), 32'(e[7:0]));
            chk($sformatf("t3_carry_%0d", n), 32'(carry), 32'(e[8]));
            chk($sformatf("t3_zero_%0d", n), 32'(zero), 32'(e[7:0] == 8'h00));
        end

        // 4: FF+01 overflow; request dropped during WAIT
        set4(0, OP_ADD, 8'hFF, 8'h01);
        req = 4'b0001;
        step();
        chk("t4_gnt", 32'(gnt), 32'h1);
        step();
        chk("t4_start", 32'(alu_start), 32'd1);
        step();
        req = 4'b0000;
        step();
        chk("t4_nodone", 32'(done), 32'd0);
        step();
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_result", 32'(result), 32'h00);
        chk("t4_zero", 32'(zero), 32'd1);
        chk("t4_carry", 32'(carry), 32'd1);
        step();
        chk("t4_gnt_clr", 32'(gnt), 32'd0);

        // 5: reset during WAIT aborts; ptr restarts at 0 afterwards
        set4(1, OP_SUB, 8'h09, 8'h03);
        req = 4'b0010;
        step();
        chk("t5_gnt", 32'(gnt), 32'h2);
        step();
        step();
        rst4 = 1'b0;
        step();
        chk("t5_rst_gnt", 32'(gnt), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_result", 32'(result), 32'd0);
        chk("t5_rst_zero", 32'(zero), 32'd1);
        set4(0, OP_ADD, 8'h03, 8'h04);
        req = 4'b0011; rst4 = 1'b1;
        step();
        chk("t5_gnt_ptr0", 32'(gnt), 32'h1);
        chk("t5_nodone_a", 32'(done), 32'd0);
        step();
        chk("t5_nodone_b", 32'(done), 32'd0);
        step();
        chk("t5_nodone_c", 32'(done), 32'd0);
        step();
        chk("t5_nodone_d", 32'(done), 32'd0);
        step();
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_result", 32'(result), 32'h07);
        req = 4'b0000;

        // 6: three requesters, latency 1 (period 4)
        for (int i = 0; i < 3; i++) begin
            op3[i*4 +: 4] = OP_ADD;
            a3[i*8 +: 8]  = 8'(8'h10 * (i + 1));
            b3[i*8 +: 8]  = 8'(i + 1);
        end
        pat[0] = 3'b101; eg[0] = 0;
        pat[1] = 3'b100; eg[1] = 2;
        pat[2] = 3'b101; eg[2] = 0;
        pat[3] = 3'b100; eg[3] = 2;
        pat[4] = 3'b101; eg[4] = 0;
        pat[5] = 3'b101; eg[5] = 2;
        pat[6] = 3'b111; eg[6] = 0;
        pat[7] = 3'b111; eg[7] = 1;
        pat[8] = 3'b111; eg[8] = 2;
        rst3 = 1'b1;
        for (int n = 0; n < 9; n++) begin
            req3 = pat[n];
            step();
            chk($sformatf("t6_gnt_%0d", n), 32'(gnt3), 32'(3'b001 << eg[n]));
            step();
            chk($sformatf("t6_start_%0d", n), 32'(alu_start3), 32'd1);
            step();
            step();
            chk($sformatf("t6_done_%0d", n), 32'(done3), 32'(3'b001 << eg[n]));
            chk($sformatf("t6_result_%0d", n), 32'(result3), 32'(8'h11 * (eg[n] + 1)));
        end
        req3 = '0;
        step();
        chk("t6_gnt_clr", 32'(gnt3), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
